parking_gate_queue: RTL and testbench

Request front-end directly upstream of `parking_lot_top`. Captures entry/exit requests from the gate (plate plus one-cycle strobe), validates them, buffers them in a small FIFO, and replays them to `parking_lot_top` one at a time as single-cycle `in_mode`/`out_mode` pulses. A new request is issued only after the core has finished the previous one. This lets the gate accept cars back-to-back while the elevator is busy.

---
 rtl/parking_pkg.sv | 29 ++
 rtl/parking_gate_queue_if.sv | 33 +++
 rtl/gate_fifo.sv | 64 ++++++
 rtl/parking_gate_queue.sv | 124 ++++++++++++
 tb/tb_parking_gate_queue.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate request front-end.
package parking_pkg;

    localparam int PLATE_W = 16;

    localparam logic MODE_IN  = 1'b1;
    localparam logic MODE_OUT = 1'b0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

    typedef struct packed {
        logic               mode;
        logic [PLATE_W-1:0] plate;
    } gate_req_t;

    // A plate is four BCD digits and may not be all zeros.
    function automatic logic is_bcd_plate(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = (plate != '0);
        for (int i = 0; i < PLATE_W / 4; i++) begin
            if (plate[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/parking_gate_queue_if.sv
// Gate-side request and core-side command signals of parking_gate_queue.
interface parking_gate_queue_if #(parameter int DEPTH = 4);
    import parking_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PLATE_W-1:0] req_plate;
    logic               req_in;
    logic               req_out;
    logic               core_busy;
    logic [PLATE_W-1:0] license_plate;
    logic               in_mode;
    logic               out_mode;
    logic               req_ack;
    logic               req_drop;
    logic               core_reject;
    logic [CNT_W-1:0]   count;
    logic               queue_full;
    logic               queue_empty;

    modport master (
        output req_plate, req_in, req_out, core_busy,
        input  license_plate, in_mode, out_mode, req_ack, req_drop,
               core_reject, count, queue_full, queue_empty
    );

    modport slave (
        input  req_plate, req_in, req_out, core_busy,
        output license_plate, in_mode, out_mode, req_ack, req_drop,
               core_reject, count, queue_full, queue_empty
    );

endinterface

// File: rtl/gate_fifo.sv
// Synchronous FIFO with registered count/full/empty; head is read combinationally.
module gate_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is refused even if a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/parking_gate_queue.sv
// Validates gate requests, queues them, and replays them to the core one at a time.
module parking_gate_queue
    import parking_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GUARD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    parking_gate_queue_if.slave  gate
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    logic [1:0]             state;
    logic [GW-1:0]          guard_cnt;
    logic                   strobe;
    logic                   valid_req;
    logic                   push;
    logic                   pop;
    gate_req_t              push_req;
    gate_req_t              head_req;
    logic [$bits(gate_req_t)-1:0] fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic [PLATE_W-1:0]     plate_q;
    logic                   in_mode_q;
    logic                   out_mode_q;
    logic                   ack_q;
    logic                   drop_q;
    logic                   reject_q;

    assign strobe         = gate.req_in | gate.req_out;
    assign valid_req      = (gate.req_in ^ gate.req_out) && is_bcd_plate(gate.req_plate);
    assign push           = valid_req && !fifo_full;
    assign push_req.mode  = gate.req_in ? MODE_IN : MODE_OUT;
    assign push_req.plate = gate.req_plate;
    assign head_req       = gate_req_t'(fifo_head);

    // The head leaves the FIFO on the same edge that enters ISSUE.
    assign pop = (state == ST_IDLE) && !fifo_empty && !gate.core_busy;

    gate_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(gate_req_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            ack_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            ack_q  <= push;
            drop_q <= strobe && !push;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            guard_cnt  <= '0;
            plate_q    <= '0;
            in_mode_q  <= 1'b0;
            out_mode_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            plate_q    <= '0;
            in_mode_q  <= 1'b0;
            out_mode_q <= 1'b0;
            reject_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state      <= ST_ISSUE;
                        plate_q    <= head_req.plate;
                        in_mode_q  <= (head_req.mode == MODE_IN);
                        out_mode_q <= (head_req.mode == MODE_OUT);
                    end
                end
                ST_ISSUE: begin
                    state     <= ST_WAIT_BUSY;
                    guard_cnt <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (gate.core_busy) begin
                        state <= ST_WAIT_IDLE;
                    end else if (guard_cnt == GW'(GUARD - 1)) begin
                        reject_q <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!gate.core_busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gate.license_plate = plate_q;
    assign gate.in_mode       = in_mode_q;
    assign gate.out_mode      = out_mode_q;
    assign gate.req_ack       = ack_q;
    assign gate.req_drop      = drop_q;
    assign gate.core_reject   = reject_q;
    assign gate.count         = fifo_count;
    assign gate.queue_full    = fifo_full;
    assign gate.queue_empty   = fifo_empty;

endmodule

// File: tb/tb_parking_gate_queue.sv
// Directed bench for parking_gate_queue with a scoreboard-driven output monitor.
module tb_parking_gate_queue;
    import parking_pkg::*;

    localparam int DEPTH = 4;
    localparam int GUARD = 8;

    typedef enum logic [2:0] {EV_ACK, EV_DROP, EV_IN, EV_OUT, EV_REJECT} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] plate;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    parking_gate_queue_if #(.DEPTH(DEPTH)) gif ();

    parking_gate_queue #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
        .clock (clock),
        .reset (reset),
        .gate  (gif)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_issue  = 0;

    ev_t gate_q[$];
    ev_t core_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_gate(input ev_kind_t kind);
        gate_q.push_back('{kind: kind, plate: 16'h0});
    endtask

    task automatic exp_core(input ev_kind_t kind, input logic [15:0] plate);
        core_q.push_back('{kind: kind, plate: plate});
    endtask

    task automatic sb_gate(input ev_kind_t kind, input string name);
        ev_t e;
        check({name, "_expected"}, 32'(gate_q.size() != 0), 32'd1);
        if (gate_q.size() != 0) begin
            e = gate_q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(e.kind));
        end
    endtask

    task automatic sb_core(input ev_kind_t kind, input logic [15:0] plate, input string name);
        ev_t e;
        check({name, "_expected"}, 32'(core_q.size() != 0), 32'd1);
        if (core_q.size() != 0) begin
            e = core_q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(e.kind));
            if (e.kind != EV_REJECT) check({name, "_plate"}, 32'(plate), 32'(e.plate));
        end
    endtask

    // Monitor: every pulse the DUT presents is matched against the scoreboard.
    always @(negedge clock) begin
        if (gif.req_ack)  sb_gate(EV_ACK, "req_ack");
        if (gif.req_drop) sb_gate(EV_DROP, "req_drop");
        if (gif.in_mode || gif.out_mode) begin
            n_issue++;
            check("single_mode", 32'(gif.in_mode & gif.out_mode), 32'd0);
            sb_core(gif.in_mode ? EV_IN : EV_OUT, gif.license_plate, "issue");
        end else begin
            check("plate_zero_outside_issue", 32'(gif.license_plate), 32'd0);
        end
        if (gif.core_reject) sb_core(EV_REJECT, 16'h0, "core_reject");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] plate, input logic i, input logic o);
        gif.req_plate = plate;
        gif.req_in    = i;
        gif.req_out   = o;
        tick(1);
        gif.req_plate = 16'h0;
        gif.req_in    = 1'b0;
        gif.req_out   = 1'b0;
    endtask

    task automatic wait_issue(input string name, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (gif.in_mode || gif.out_mode) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_reject(input string name, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (gif.core_reject) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c_push, c_iss, c_rej, c_next, n_mark;

        gif.req_plate = 16'h0;
        gif.req_in    = 1'b0;
        gif.req_out   = 1'b0;
        gif.core_busy = 1'b0;

        // Reset held low for two cycles.
        reset = 1'b0;
        tick(2);
        check("rst_count", 32'(gif.count), 32'd0);
        check("rst_empty", 32'(gif.queue_empty), 32'd1);
        check("rst_full", 32'(gif.queue_full), 32'd0);
        check("rst_plate", 32'(gif.license_plate), 32'd0);
        check("rst_pulses", 32'({gif.in_mode, gif.out_mode, gif.req_ack, gif.req_drop, gif.core_reject}), 32'd0);
        reset = 1'b1;
        tick(2);

        // Single entry with the core idle: one cycle of issue latency.
        exp_gate(EV_ACK);
        exp_core(EV_IN, 16'h8754);
        send(16'h8754, 1'b1, 1'b0);
        c_push = cyc;
        check("t1_count_push", 32'(gif.count), 32'd1);
        wait_issue("t1_issue_seen", c_iss);
        check("t1_issue_latency", 32'(c_iss - c_push), 32'd1);
        check("t1_count_pop", 32'(gif.count), 32'd0);
        gif.core_busy = 1'b1;
        tick(5);
        gif.core_busy = 1'b0;
        tick(2);

        // Two requests queued behind a busy core, issued in order.
        gif.core_busy = 1'b1;
        exp_gate(EV_ACK);
        exp_gate(EV_ACK);
        exp_core(EV_IN, 16'h9423);
        exp_core(EV_OUT, 16'h8754);
        send(16'h9423, 1'b1, 1'b0);
        send(16'h8754, 1'b0, 1'b1);
        check("t2_count", 32'(gif.count), 32'd2);
        n_mark = n_issue;
        tick(2);
        check("t2_hold_while_busy", 32'(n_issue - n_mark), 32'd0);
        gif.core_busy = 1'b0;
        wait_issue("t2_first_issue", c_iss);
        gif.core_busy = 1'b1;
        check("t2_count_after_first", 32'(gif.count), 32'd1);
        tick(1);
        n_mark = n_issue;
        tick(3);
        check("t2_second_waits", 32'(n_issue - n_mark), 32'd0);
        gif.core_busy = 1'b0;
        wait_issue("t2_second_issue", c_iss);
        gif.core_busy = 1'b1;
        tick(2);
        gif.core_busy = 1'b0;
        tick(2);
        check("t2_drained", 32'(gif.count), 32'd0);

        // Invalid requests: non-BCD nibble, zero plate, both strobes.
        exp_gate(EV_DROP);
        exp_gate(EV_DROP);
        exp_gate(EV_DROP);
        send(16'h87A4, 1'b1, 1'b0);
        check("t3_count_non_bcd", 32'(gif.count), 32'd0);
        send(16'h0000, 1'b0, 1'b1);
        check("t3_count_zero_plate", 32'(gif.count), 32'd0);
        send(16'h1234, 1'b1, 1'b1);
        check("t3_count_both_strobes", 32'(gif.count), 32'd0);
        tick(2);

        // Fill, overflow, then push and pop on the same edge across pointer wrap.
        gif.core_busy = 1'b1;
        exp_gate(EV_ACK);
        exp_gate(EV_ACK);
        exp_gate(EV_ACK);
        exp_gate(EV_ACK);
        exp_gate(EV_DROP);
        exp_gate(EV_ACK);
        exp_core(EV_IN, 16'h1001);
        exp_core(EV_OUT, 16'h2002);
        exp_core(EV_IN, 16'h3003);
        exp_core(EV_OUT, 16'h4004);
        exp_core(EV_IN, 16'h6006);
        send(16'h1001, 1'b1, 1'b0);
        send(16'h2002, 1'b0, 1'b1);
        send(16'h3003, 1'b1, 1'b0);
        send(16'h4004, 1'b0, 1'b1);
        check("t4_count_full", 32'(gif.count), 32'd4);
        check("t4_full", 32'(gif.queue_full), 32'd1);
        check("t4_not_empty", 32'(gif.queue_empty), 32'd0);
        send(16'h5005, 1'b1, 1'b0);
        check("t4_count_overflow", 32'(gif.count), 32'd4);
        check("t4_full_overflow", 32'(gif.queue_full), 32'd1);
        gif.core_busy = 1'b0;
        wait_issue("t4_pop1", c_iss);
        gif.core_busy = 1'b1;
        check("t4_count_after_pop", 32'(gif.count), 32'd3);
        check("t4_not_full", 32'(gif.queue_full), 32'd0);
        tick(3);
        gif.core_busy = 1'b0;
        tick(1);
        send(16'h6006, 1'b1, 1'b0);
        gif.core_busy = 1'b1;
        check("t4_push_pop_count", 32'(gif.count), 32'd3);
        check("t4_push_pop_issue", 32'(gif.out_mode), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(3);
            gif.core_busy = 1'b0;
            wait_issue("t4_drain_issue", c_iss);
            gif.core_busy = 1'b1;
        end
        tick(3);
        gif.core_busy = 1'b0;
        tick(2);
        check("t4_drained_count", 32'(gif.count), 32'd0);
        check("t4_drained_empty", 32'(gif.queue_empty), 32'd1);

        // Core never goes busy: reject after the guard window, then the next entry issues.
        exp_gate(EV_ACK);
        exp_gate(EV_ACK);
        exp_core(EV_IN, 16'h7007);
        exp_core(EV_REJECT, 16'h0);
        exp_core(EV_OUT, 16'h8008);
        send(16'h7007, 1'b1, 1'b0);
        wait_issue("t5_issue", c_iss);
        send(16'h8008, 1'b0, 1'b1);
        wait_reject("t5_reject", c_rej);
        // ISSUE cycle, then GUARD cycles in WAIT_BUSY before the registered reject.
        check("t5_reject_delay", 32'(c_rej - c_iss), 32'(GUARD + 1));
        wait_issue("t5_next_issue", c_next);
        check("t5_next_after_reject", 32'(c_next - c_rej), 32'd1);
        gif.core_busy = 1'b1;
        tick(3);

        // Reset during WAIT_IDLE discards queued entries; nothing is issued afterwards.
        exp_gate(EV_ACK);
        exp_gate(EV_ACK);
        send(16'h1111, 1'b1, 1'b0);
        send(16'h2222, 1'b0, 1'b1);
        check("t6_count_before_reset", 32'(gif.count), 32'd2);
        reset         = 1'b0;
        gif.core_busy = 1'b0;
        tick(2);
        check("t6_rst_count", 32'(gif.count), 32'd0);
        check("t6_rst_empty", 32'(gif.queue_empty), 32'd1);
        check("t6_rst_full", 32'(gif.queue_full), 32'd0);
        reset = 1'b1;
        tick(1);
        n_mark = n_issue;
        tick(12);
        check("t6_no_issue_after_reset", 32'(n_issue - n_mark), 32'd0);

        check("gate_scoreboard_drained", 32'(gate_q.size()), 32'd0);
        check("core_scoreboard_drained", 32'(core_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
